// File: rtl/zeroheti_pkg.sv
// rtl/zeroheti_pkg.sv - shared types and constants for the zeroheti OBI-to-APB bridge
package zeroheti_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2,
    APB_RESP   = 2'd3
  } apb_bridge_state_e;

  localparam int unsigned ApbTimeoutDefault = 255;
  localparam logic [2:0]  ApbProtDefault    = 3'b000;

endpackage

// File: rtl/zeroheti_apb_timeout_cnt.sv
// rtl/zeroheti_apb_timeout_cnt.sv - saturating ACCESS-phase watchdog counter
module zeroheti_apb_timeout_cnt #(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  if (TimeoutCycles == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk_i, rst_ni, clr_i, en_i};
    assign expired_o     = 1'b0;
  end else begin : g_cnt
    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] Limit = CntWidth'(TimeoutCycles);

    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] cnt_inc;

    always_comb begin
      cnt_inc = (cnt_q == Limit) ? cnt_q : cnt_q + CntWidth'(1);
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (clr_i) begin
        cnt_q <= '0;
      end else if (en_i) begin
        cnt_q <= cnt_inc;
      end
    end

    // Fires in the cycle whose increment brings the count to the limit.
    assign expired_o = en_i && (cnt_inc == Limit);
  end

endmodule

// File: rtl/zeroheti_obi_apb_bridge.sv
// rtl/zeroheti_obi_apb_bridge.sv - single-outstanding OBI subordinate to APB4 manager bridge
module zeroheti_obi_apb_bridge
  import zeroheti_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = ApbTimeoutDefault
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   obi_req_i,
  output logic                   obi_gnt_o,
  input  logic [AddrWidth-1:0]   obi_addr_i,
  input  logic                   obi_we_i,
  input  logic [DataWidth/8-1:0] obi_be_i,
  input  logic [DataWidth-1:0]   obi_wdata_i,
  output logic                   obi_rvalid_o,
  output logic [DataWidth-1:0]   obi_rdata_o,
  output logic                   obi_err_o,
  output logic [AddrWidth-1:0]   paddr_o,
  output logic                   psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [DataWidth-1:0]   pwdata_o,
  output logic [DataWidth/8-1:0] pstrb_o,
  output logic [2:0]             pprot_o,
  input  logic [DataWidth-1:0]   prdata_i,
  input  logic                   pready_i,
  input  logic                   pslverr_i
);

  localparam int unsigned BeWidth = DataWidth / 8;

  apb_bridge_state_e state_q, state_d;

  logic [AddrWidth-1:0] addr_q;
  logic                 we_q;
  logic [BeWidth-1:0]   strb_q;
  logic [DataWidth-1:0] wdata_q;
  logic [DataWidth-1:0] rdata_q;
  logic                 err_q;
  logic                 cnt_clr;
  logic                 cnt_en;
  logic                 expired;

  zeroheti_apb_timeout_cnt #(
    .TimeoutCycles(TimeoutCycles)
  ) i_timeout_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .expired_o(expired)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= APB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    obi_gnt_o    = 1'b0;
    obi_rvalid_o = 1'b0;
    psel_o       = 1'b0;
    penable_o    = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    case (state_q)
      APB_IDLE: begin
        obi_gnt_o = 1'b1;
        if (obi_req_i) begin
          state_d = APB_SETUP;
          cnt_clr = 1'b1;
        end
      end
      APB_SETUP: begin
        psel_o  = 1'b1;
        state_d = APB_ACCESS;
      end
      APB_ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        cnt_en    = 1'b1;
        if (pready_i || expired) begin
          state_d = APB_RESP;
        end
      end
      APB_RESP: begin
        obi_rvalid_o = 1'b1;
        state_d      = APB_IDLE;
      end
      default: state_d = APB_IDLE;
    endcase
  end

  // Request fields are frozen at the grant so the APB side stays stable through ACCESS.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      strb_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == APB_IDLE && obi_req_i) begin
        addr_q  <= {obi_addr_i[AddrWidth-1:2], 2'b00};
        we_q    <= obi_we_i;
        strb_q  <= obi_we_i ? obi_be_i : '0;
        wdata_q <= obi_wdata_i;
      end
      if (state_q == APB_ACCESS) begin
        if (pready_i) begin
          err_q   <= pslverr_i;
          rdata_q <= (we_q || pslverr_i) ? '0 : prdata_i;
        end else if (expired) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
      end
    end
  end

  assign paddr_o     = addr_q;
  assign pwrite_o    = we_q;
  assign pwdata_o    = wdata_q;
  assign pstrb_o     = strb_q;
  assign pprot_o     = ApbProtDefault;
  assign obi_rdata_o = obi_rvalid_o ? rdata_q : '0;
  assign obi_err_o   = obi_rvalid_o ? err_q : 1'b0;

endmodule

// File: doc/zeroheti_obi_apb_bridge.md
# zeroheti_obi_apb_bridge

Converts single OBI transactions from the core crossbar's APB subordinate port into APB4 transfers for the peripheral subsystem (CLIC, timers, UART). It is the stage directly downstream of the crossbar's `apb_sbr` port. It handles one outstanding transaction at a time, maps APB errors onto OBI `err`, and terminates hung transfers with a bus error after a programmable timeout.

## Interface
Parameters:
- `AddrWidth`, 32, OBI and APB address width.
- `DataWidth`, 32, data width; byte-enable width is `DataWidth/8`.
- `TimeoutCycles`, 255, maximum ACCESS-phase cycles before forced error; 0 disables the timeout.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
  - `clk_i`  in  1  clock.
  - `rst_ni`  in  1  reset.
- OBI subordinate side:
  - `obi_req_i`  in  1  request.
  - `obi_gnt_o`  out  1  grant.
  - `obi_addr_i`  in  AddrWidth  byte address.
  - `obi_we_i`  in  1  write enable.
  - `obi_be_i`  in  DataWidth/8  byte enables.
  - `obi_wdata_i`  in  DataWidth  write data.
  - `obi_rvalid_o`  out  1  response valid.
  - `obi_rdata_o`  out  DataWidth  read data.
  - `obi_err_o`  out  1  response error.
- APB4 manager side:
  - `paddr_o`  out  AddrWidth  word-aligned address.
  - `psel_o`, `penable_o`, `pwrite_o`  out  1 each  APB controls.
  - `pwdata_o`  out  DataWidth  write data.
  - `pstrb_o`  out  DataWidth/8  write strobes.
  - `pprot_o`  out  3  constant 3'b000.
  - `prdata_i`  in  DataWidth  read data.
  - `pready_i`  in  1  ready.
  - `pslverr_i`  in  1  slave error.

## Operation
- FSM states are IDLE, SETUP, ACCESS and RESP.
- IDLE:
  - `obi_gnt_o` is 1 combinationally whenever the state is IDLE, independent of `obi_req_i`.
  - `obi_req_i` together with `obi_gnt_o` latches the request: address with bits [1:0] cleared, `we`, `be`, `wdata`. The FSM then goes to SETUP.
- SETUP: `psel_o`=1, `penable_o`=0. The FSM always goes to ACCESS.
- ACCESS: `psel_o`=1, `penable_o`=1. The timeout counter increments each cycle.
  - `pready_i`=1: capture `prdata_i` (reads only) and `pslverr_i`, then go to RESP.
  - Counter reaches `TimeoutCycles` (when nonzero) without `pready_i`: set `err`=1, `rdata`=0, go to RESP. `pready_i` arriving in that same cycle wins and gives a normal completion.
- RESP:
  - `obi_rvalid_o`=1 for exactly one cycle. OBI has no response backpressure.
  - `obi_err_o` equals the captured error.
  - `obi_rdata_o` is the captured data. It is forced to 0 on writes and on error.
  - The FSM always goes to IDLE.
- `pstrb_o` = latched `be` for writes and 0 for reads (APB4 rule). A write with `be`=0 still performs the APB transfer.
- `paddr_o`, `pwrite_o`, `pwdata_o` and `pstrb_o` are registered and hold stable from SETUP through the end of ACCESS.
- The timeout counter is `$clog2(TimeoutCycles+1)` bits wide. It clears on entry to SETUP and saturates, never wrapping.

## Timing
- Reset values (all outputs): 0, apart from `obi_gnt_o`.
  - State is IDLE, so `obi_gnt_o`=1 from the first cycle after reset.
  - Latched fields and the counter are 0.
- Reset mid-operation: the next edge forces IDLE and drops `psel_o`/`penable_o` immediately. The in-flight transaction is lost and no `rvalid` is issued.
- Latency with `pready_i` high on the first ACCESS cycle:
  - grant at cycle 0;
  - SETUP at cycle 1;
  - ACCESS at cycle 2;
  - `rvalid` at cycle 3;
  - next grant at cycle 4.
  - Throughput is one transaction per 4 cycles, plus N extra cycles for N wait states.
- Timeout response: `rvalid` arrives `TimeoutCycles`+2 cycles after grant.
- `obi_gnt_o` is never asserted while a transaction is outstanding. `obi_req_i` held in SETUP/ACCESS/RESP is ignored until IDLE.

## Structure
- `zeroheti_pkg` additions:
  - `apb_bridge_state_e` enum (IDLE, SETUP, ACCESS, RESP).
  - `ApbTimeoutDefault` = 255.
  - Constant `ApbProtDefault` = 3'b000.
- Sub-module `zeroheti_apb_timeout_cnt`: a saturating counter with `clr`/`en` inputs and an `expired` output, parameterised by `TimeoutCycles` and tied off when that is 0.
- The top level instantiates the FSM and the capture registers only. It is wired to the crossbar `apb_sbr` OBI_BUS in `zeroheti_core`.

## Test plan
- Read at 0x0000_3004, `pready_i`=1 immediately, `prdata_i`=0xDEAD_BEEF:
  - `paddr_o`=0x3004;
  - `pstrb_o`=0;
  - `rvalid` at cycle 3 with `rdata`=0xDEAD_BEEF and `err`=0.
- Write 0x1234_5678, `be`=4'b0011, to 0x0000_3006 with 2 wait states:
  - `paddr_o`=0x3004;
  - `pwdata_o` and `pstrb_o` stable for 3 ACCESS cycles;
  - `rvalid` at cycle 5 with `rdata`=0.
- Read with `pslverr_i`=1 and `prdata_i`=0xFFFF_FFFF: `rvalid` with `err`=1 and `rdata`=0.
- `TimeoutCycles`=4, `pready_i` held 0:
  - `psel_o` drops after 4 ACCESS cycles;
  - `rvalid` with `err`=1 at cycle 6;
  - bridge returns to IDLE with grant asserted.
- `obi_req_i` held high continuously: grants at cycles 0, 4, 8, and no grant in any other cycle.
- `rst_ni` low during ACCESS: `psel_o`=`penable_o`=0 at the next edge, no `rvalid`, and grant reasserts after `rst_ni` rises.
